// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, frame bit constants and frame builder for the UART tx arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  localparam logic STOP_BIT = 1'b1;
  localparam logic START_BIT = 1'b0;
  function automatic logic [9:0] frame(input logic [7:0] b);
    return {STOP_BIT, b, START_BIT};
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: 2-flop synchroniser, async active-low reset to 0
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte requesters,
// with tx_en sequencing against synchronised tx_Busy/tx_Done and a sticky timeout error.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  input  logic                 tx_Busy,
  input  logic                 tx_Done,
  output logic                 tx_en,
  output logic [9:0]           txin_data,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);
  localparam int LW = $clog2(N_REQ);
  state_t state_q, state_d;
  logic busy_s, done_s, done_q, done_rise, timeout, active;
  logic [LW-1:0] last_q, last_d, cur_q, cur_d, win;
  logic [15:0] timer_q, timer_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, pulse_q, pulse_d;
  logic tx_en_q, tx_en_d, err_q, err_d;
  logic [9:0] txin_q, txin_d;

  uart_sync2 u_sync_busy (.clk(clk), .rst(rst), .d(tx_Busy), .q(busy_s));
  uart_sync2 u_sync_done (.clk(clk), .rst(rst), .d(tx_Done), .q(done_s));

  // First requester after l in circular order; l itself is searched last.
  function automatic logic [LW-1:0] next_idx(input logic [N_REQ-1:0] r, input logic [LW-1:0] l);
    logic [LW-1:0] idx;
    next_idx = l;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = LW'((int'(l) + k) % N_REQ);
      if (r[idx]) next_idx = idx;
    end
  endfunction

  assign win = next_idx(req, last_q);
  assign done_rise = done_s & ~done_q;
  assign active = (state_q == START) || (state_q == WAIT);
  assign timeout = active && (timer_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cur_d = cur_q;
    gnt_d = '0;
    pulse_d = '0;
    tx_en_d = tx_en_q;
    txin_d = txin_q;
    timer_d = active ? timer_q + 16'd1 : timer_q;
    err_d = err_clr ? 1'b0 : err_q;
    if (timeout) begin
      state_d = GAP;
      tx_en_d = 1'b0;
      err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          gnt_d = N_REQ'(1) << win;
          txin_d = frame(req_data[{win, 3'b000} +: 8]);
          tx_en_d = 1'b1;
          timer_d = '0;
          cur_d = win;
          last_d = win;
          state_d = START;
        end
        START: if (busy_s) begin
          tx_en_d = 1'b0;
          state_d = WAIT;
        end
        WAIT: if (done_rise) begin
          pulse_d = N_REQ'(1) << cur_q;
          state_d = GAP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      last_q <= '0;
      cur_q <= '0;
      timer_q <= '0;
      gnt_q <= '0;
      pulse_q <= '0;
      tx_en_q <= 1'b0;
      txin_q <= 10'h3FF;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cur_q <= cur_d;
      timer_q <= timer_d;
      gnt_q <= gnt_d;
      pulse_q <= pulse_d;
      tx_en_q <= tx_en_d;
      txin_q <= txin_d;
      err_q <= err_d;
      done_q <= done_s;
    end

  assign gnt = gnt_q;
  assign done = pulse_q;
  assign tx_en = tx_en_q;
  assign txin_data = txin_q;
  assign busy = state_q != IDLE;
  assign err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter with a hand-driven transmitter.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst, tx_Busy, tx_Done, err_clr;
  logic [3:0] req, gnt, done;
  logic [31:0] req_data;
  logic tx_en, busy, err;
  logic [9:0] txin_data;
  int checks = 0;
  int errors = 0;

  typedef struct { int idx; logic [7:0] data; } gexp_t;
  gexp_t gq[$];
  int dq[$];
  gexp_t mon_g;
  int mon_d;
  logic [9:0] mon_f;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .tx_Busy(tx_Busy), .tx_Done(tx_Done), .tx_en(tx_en), .txin_data(txin_data),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (gnt === 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_wait", 32'(gnt !== 4'b0), 1);
  endtask

  task automatic finish_frame(input int busy_len, input logic hold_done);
    tx_Busy = 1'b1;
    repeat (2) begin @(negedge clk); chk("tx_en_hold", 32'(tx_en), 1); end
    @(negedge clk); chk("tx_en_fall", 32'(tx_en), 0);
    repeat (busy_len) @(negedge clk);
    tx_Busy = 1'b0;
    tx_Done = 1'b1;
    repeat (2) begin @(negedge clk); chk("done_early", 32'(done), 0); end
    @(negedge clk); chk("done_pulse", 32'(done !== 4'b0), 1);
    if (!hold_done) tx_Done = 1'b0;
    @(negedge clk); chk("gap_to_idle", 32'(busy), 0);
  endtask

  always @(negedge clk) if (rst) begin
    if (gnt !== 4'b0) begin
      chk("gnt_expected", 32'(gq.size() != 0), 1);
      if (gq.size() != 0) begin
        mon_g = gq.pop_front();
        mon_f = {1'b1, mon_g.data, 1'b0};
        chk("gnt_idx", 32'(gnt), 32'(1) << mon_g.idx);
        chk("txin_data", 32'(txin_data), 32'(mon_f));
      end
    end
    if (done !== 4'b0) begin
      chk("done_expected", 32'(dq.size() != 0), 1);
      if (dq.size() != 0) begin
        mon_d = dq.pop_front();
        chk("done_idx", 32'(done), 32'(1) << mon_d);
      end
    end
    if ((gnt | done) !== 4'b0) chk("gnt_done_excl", 32'(gnt & done), 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_Busy = 1'b0; tx_Done = 1'b0; err_clr = 1'b0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_txin", 32'(txin_data), 32'h3FF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    @(negedge clk);
    // single request, tx_en must wait for the transmitter
    req_data[7:0] = 8'hA5;
    gq.push_back('{0, 8'hA5});
    dq.push_back(0);
    req = 4'b0001;
    wait_gnt();
    req = '0;
    chk("single_txin", 32'(txin_data), 32'h34A);
    chk("single_busy", 32'(busy), 1);
    repeat (3) begin @(negedge clk); chk("single_tx_en_wait", 32'(tx_en), 1); end
    finish_frame(3, 1'b0);
    // fairness with all requesters held
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int f = 0; f < 8; f++) begin
      gq.push_back('{(f + 1) % 4, 8'(16 + (f + 1) % 4)});
      dq.push_back((f + 1) % 4);
    end
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_gnt();
      if (f == 7) req = '0;
      finish_frame(2, 1'b0);
    end
    // stale tx_Done held across GAP into the next grant
    req_data[23:16] = 8'h5A;
    gq.push_back('{2, 8'h5A}); dq.push_back(2);
    gq.push_back('{2, 8'h5A}); dq.push_back(2);
    req = 4'b0100;
    wait_gnt();
    finish_frame(2, 1'b1);
    wait_gnt();
    req = '0;
    tx_Busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("stale_tx_en_fall", 32'(tx_en), 0);
    repeat (6) begin @(negedge clk); chk("stale_no_done", 32'(done), 0); end
    tx_Busy = 1'b0;
    tx_Done = 1'b0;
    repeat (3) @(negedge clk);
    tx_Done = 1'b1;
    repeat (2) begin @(negedge clk); chk("fresh_done_early", 32'(done), 0); end
    @(negedge clk); chk("fresh_done_pulse", 32'(done !== 4'b0), 1);
    tx_Done = 1'b0;
    @(negedge clk);
    // timeout with err_clr coinciding
    req_data[15:8] = 8'h3C;
    gq.push_back('{1, 8'h3C});
    req = 4'b0010;
    wait_gnt();
    req = '0;
    repeat (31) begin @(negedge clk); chk("to_tx_en_high", 32'(tx_en), 1); end
    chk("to_err_before", 32'(err), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_tx_en_fall", 32'(tx_en), 0);
    chk("to_err_set", 32'(err), 1);
    chk("to_gap_busy", 32'(busy), 1);
    @(negedge clk);
    chk("to_idle", 32'(busy), 0);
    chk("to_err_sticky", 32'(err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 0);
    // reset during WAIT, held request re-granted afterwards
    req_data[31:24] = 8'hC3;
    gq.push_back('{3, 8'hC3});
    req = 4'b1000;
    wait_gnt();
    tx_Busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_wait_tx_en", 32'(tx_en), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tx_en", 32'(tx_en), 0);
    chk("mid_rst_txin", 32'(txin_data), 32'h3FF);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    tx_Busy = 1'b0;
    @(negedge clk);
    gq.push_back('{3, 8'hC3});
    dq.push_back(3);
    rst = 1'b1;
    wait_gnt();
    req = '0;
    finish_frame(2, 1'b0);
    repeat (4) @(negedge clk);
    chk("gnt_queue_empty", 32'(gq.size()), 0);
    chk("done_queue_empty", 32'(dq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
